// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared state encoding, port identifiers and counter sizing
// for the dm_4k data-memory arbiter.
`default_nettype none

package dm_arbiter_pkg;

  localparam int unsigned ST_W  = 2;
  localparam int unsigned CNT_W = 4;

  localparam logic [ST_W-1:0] ARB_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ARB_ACCESS = 2'd1;
  localparam logic [ST_W-1:0] ARB_RESP   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dm_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick. On a tie the port that
// was not served last wins.
`default_nettype none

module rr_arb2
  import dm_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic gnt_o,
  output logic valid_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    gnt_o   = PORT_CPU;
    if (req0_i && req1_i) begin
      gnt_o = ~last_i;
    end else if (req1_i) begin
      gnt_o = PORT_DMA;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the CPU and DMA
// ports; each grant runs a fixed LAT-cycle access followed by a done pulse.
`default_nettype none

module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_done_o,

  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_done_o,

  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_dout_i,

  output logic              busy_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  logic [ST_W-1:0]   state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic gnt;
  logic gnt_valid;
  logic last_beat;

  rr_arb2 u_rr_arb2 (
    .req0_i  (cpu_req_i),
    .req1_i  (dma_req_i),
    .last_i  (rr_last_q),
    .gnt_o   (gnt),
    .valid_o (gnt_valid)
  );

  assign last_beat = (cnt_q == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (gnt_valid) state_d = ARB_ACCESS;
      ARB_ACCESS: if (last_beat) state_d = ARB_RESP;
      ARB_RESP:   state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Transaction latches, access counter and per-port read-data capture
  always_comb begin
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    if (state_q == ARB_IDLE && gnt_valid) begin
      owner_d   = gnt;
      rr_last_d = gnt;
      cnt_d     = CNT_LOAD;
      if (gnt == PORT_DMA) begin
        we_d    = dma_we_i;
        addr_d  = dma_addr_i;
        wdata_d = dma_wdata_i;
      end else begin
        we_d    = cpu_we_i;
        addr_d  = cpu_addr_i;
        wdata_d = cpu_wdata_i;
      end
    end

    if (state_q == ARB_ACCESS) begin
      if (!last_beat) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (!we_q) begin
        if (owner_q == PORT_DMA) begin
          dma_rdata_d = mem_dout_i;
        end else begin
          cpu_rdata_d = mem_dout_i;
        end
      end
    end
  end

  // Reset leaves rr_last on DMA so the CPU wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q   <= PORT_DMA;
      owner_q     <= PORT_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      rr_last_q   <= rr_last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Output logic
  always_comb begin
    mem_addr_o = '0;
    mem_din_o  = '0;
    mem_we_o   = 1'b0;
    busy_o     = 1'b0;
    cpu_done_o = 1'b0;
    dma_done_o = 1'b0;
    case (state_q)
      ARB_ACCESS: begin
        mem_addr_o = addr_q;
        mem_din_o  = wdata_q;
        mem_we_o   = we_q & last_beat;
        busy_o     = 1'b1;
      end
      ARB_RESP: begin
        busy_o     = 1'b1;
        cpu_done_o = (owner_q == PORT_CPU);
        dma_done_o = (owner_q == PORT_DMA);
      end
      default: ;
    endcase
  end

  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: three arbiter instances (LAT=1,2,3), each with its own
// memory, directed scenarios and random traffic against a transaction model.
`default_nettype none

module tb_dm_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_lat
    localparam int L = gi + 1;

    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_done;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_done;
    logic [9:0]  dma_addr;
    logic [31:0] dma_wdata, dma_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic        mem_we, busy;
    bit          fin = 1'b0;

    dm_arbiter #(.ADDR_W(10), .DATA_W(32), .LAT(L)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cpu_req_i   (cpu_req),
      .cpu_we_i    (cpu_we),
      .cpu_addr_i  (cpu_addr),
      .cpu_wdata_i (cpu_wdata),
      .cpu_rdata_o (cpu_rdata),
      .cpu_done_o  (cpu_done),
      .dma_req_i   (dma_req),
      .dma_we_i    (dma_we),
      .dma_addr_i  (dma_addr),
      .dma_wdata_i (dma_wdata),
      .dma_rdata_o (dma_rdata),
      .dma_done_o  (dma_done),
      .mem_addr_o  (mem_addr),
      .mem_din_o   (mem_din),
      .mem_we_o    (mem_we),
      .mem_dout_i  (mem_dout),
      .busy_o      (busy)
    );

    // dm_4k stand-in: combinational read, write on the rising edge
    logic [31:0] mem [1024];
    assign mem_dout = mem[mem_addr];
    initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
      mem[5] = 32'hDEADBEEF;
      forever begin
        @(posedge clk);
        if (mem_we === 1'b1) mem[mem_addr] <= mem_din;
      end
    end

    // Transaction-level model: a grant at cycle g occupies g+1..g+L+1
    initial begin
      logic [31:0] rmem [1024];
      logic [31:0] erd [2];
      logic [9:0]  maddr;
      logic [31:0] mwd;
      bit          act, own, mwe, last, in_acc, in_resp, wr_cyc;
      int          cyc, st, k;
      string       p;
      for (int i = 0; i < 1024; i++) rmem[i] = 32'hC0DE0000 | 32'(i);
      rmem[5] = 32'hDEADBEEF;
      act = 0; own = 0; mwe = 0; last = 1; cyc = 0; st = 0;
      maddr = '0; mwd = '0; erd[0] = '0; erd[1] = '0;
      p = $sformatf("L%0d", L);
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          act = 0; last = 1; erd[0] = '0; erd[1] = '0;
          in_acc = 0; in_resp = 0; wr_cyc = 0;
        end else begin
          k       = cyc - st;
          in_acc  = act && k >= 0 && k < L;
          in_resp = act && k == L;
          wr_cyc  = in_acc && k == L - 1;
        end
        chk({p, " mem_addr"},  32'(mem_addr), in_acc ? 32'(maddr) : 32'h0);
        chk({p, " mem_din"},   mem_din,       in_acc ? mwd : 32'h0);
        chk({p, " mem_we"},    32'(mem_we),   32'(wr_cyc && mwe));
        chk({p, " busy"},      32'(busy),     32'(in_acc || in_resp));
        chk({p, " cpu_done"},  32'(cpu_done), 32'(in_resp && own == 1'b0));
        chk({p, " dma_done"},  32'(dma_done), 32'(in_resp && own == 1'b1));
        chk({p, " cpu_rdata"}, cpu_rdata,     erd[0]);
        chk({p, " dma_rdata"}, dma_rdata,     erd[1]);
        if (rst_n === 1'b1) begin
          if (wr_cyc) begin
            if (mwe) rmem[maddr] = mwd;
            else     erd[own]    = rmem[maddr];
          end
          if (in_resp) begin
            act = 0;
          end else if (!act && (cpu_req || dma_req)) begin
            own   = (cpu_req && dma_req) ? !last : dma_req;
            last  = own;
            mwe   = own ? dma_we    : cpu_we;
            maddr = own ? dma_addr  : cpu_addr;
            mwd   = own ? dma_wdata : cpu_wdata;
            st    = cyc + 1;
            act   = 1;
          end
        end
        cyc++;
      end
    end

    // Issue one transaction; returns cycles from req to the done cycle inclusive
    task automatic txn(input bit pt, input bit we, input logic [9:0] a,
                       input logic [31:0] d, output int n);
      if (pt) begin
        dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
      end else begin
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
      end
      for (n = 1; n <= 200; n++) begin
        @(negedge clk);
        if ((pt ? dma_done : cpu_done) === 1'b1) break;
      end
      if (n > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL L%0d done timeout port %0d: got none required done", L, pt);
      end
      @(posedge clk); #1;
      if (pt) dma_req = 1'b0; else cpu_req = 1'b0;
    endtask

    task automatic rnd(input bit pt);
      int n, k;
      repeat (25) begin
        k = $urandom_range(0, 3);
        if (k > 0) begin
          repeat (k) @(posedge clk);
          #1;
        end
        txn(pt, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom, n);
      end
    endtask

    initial begin
      int n, ne;
      int ev_p [4];
      int ev_c [4];
      rst_n = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      txn(1'b0, 1'b0, 10'd5, 32'h0, n);
      chk($sformatf("L%0d cpu read latency", L), n, L + 2);
      chk($sformatf("L%0d cpu read mem5", L), cpu_rdata, 32'hDEADBEEF);

      txn(1'b1, 1'b1, 10'd10, 32'h12345678, n);
      chk($sformatf("L%0d dma write latency", L), n, L + 2);
      chk($sformatf("L%0d mem10 after write", L), mem[10], 32'h12345678);
      txn(1'b0, 1'b0, 10'd10, 32'h0, n);
      chk($sformatf("L%0d cpu readback 10", L), cpu_rdata, 32'h12345678);

      // Both ports held from reset: CPU first, then strict alternation
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cpu_we = 0; cpu_addr = 10'd1; dma_we = 0; dma_addr = 10'd2;
      cpu_req = 1; dma_req = 1; rst_n = 1'b1;
      ne = 0;
      for (int c = 0; c < 200 && ne < 4; c++) begin
        @(negedge clk);
        if (cpu_done === 1'b1 || dma_done === 1'b1) begin
          ev_p[ne] = (dma_done === 1'b1) ? 1 : 0;
          ev_c[ne] = c;
          ne++;
        end
      end
      @(posedge clk); #1;
      cpu_req = 0; dma_req = 0;
      chk($sformatf("L%0d both-held done count", L), ne, 4);
      if (ne == 4) begin
        chk($sformatf("L%0d first done cycle", L), ev_c[0], L + 1);
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("L%0d grant order %0d", L, i), ev_p[i], i % 2);
          if (i > 0) chk($sformatf("L%0d done spacing %0d", L, i), ev_c[i] - ev_c[i-1], L + 2);
        end
      end

      // Reset asserted during the write-pulse cycle aborts the write
      cpu_we = 1; cpu_addr = 10'd3; cpu_wdata = 32'hA5A5A5A5; cpu_req = 1;
      for (n = 0; n < 50; n++) begin
        @(posedge clk); #1;
        if (mem_we === 1'b1) break;
      end
      chk($sformatf("L%0d cycles to write pulse", L), n, L - 1);
      rst_n = 1'b0;
      cpu_req = 0;
      @(posedge clk); #1;
      chk($sformatf("L%0d mem3 after aborted write", L), mem[3], 32'hC0DE0003);
      chk($sformatf("L%0d busy in reset", L), 32'(busy), 32'h0);
      chk($sformatf("L%0d cpu_done in reset", L), 32'(cpu_done), 32'h0);
      rst_n = 1'b1;

      fork
        rnd(1'b0);
        rnd(1'b1);
      join
      repeat (3) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    for (t = 0; t < 40000; t++) begin
      @(posedge clk);
      if (g_lat[0].fin && g_lat[1].fin && g_lat[2].fin) break;
    end
    if (t >= 40000) begin
      n_cmp++; n_bad++;
      $display("FAIL global timeout: got unfinished instances required all finished");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-requester arbiter and access sequencer for the single-port data memory (dm_4k).
- Shares the memory between the multicycle CPU data port and a DMA/loader port.
- Each granted transaction runs for a fixed, parameterised access latency.
- A one-cycle done pulse tells the requester the access is complete; the CPU controller holds its memory state until cpu_done.

Parameters:
ADDR_W, 10, word-address width (matches dm_4k addr[11:2])
DATA_W, 32, data width
LAT, 2, memory access cycles per transaction, legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU request level
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, registered
cpu_done  out  1  CPU transaction complete, one-cycle pulse
dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_done  same widths and meaning, DMA port
mem_addr  out  ADDR_W  to dm_4k addr
mem_din  out  DATA_W  to dm_4k din
mem_we  out  1  to dm_4k DMWr
mem_dout  in  DATA_W  from dm_4k dout (combinational read)
busy  out  1  high while in ACCESS or RESP

Behaviour:
- Reset values (rst low, asynchronous): every output 0, state IDLE, rr_last = DMA (so the CPU wins the first tie), access counter 0, latched fields 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req high: grant that port.
  - Both high: grant the port not equal to rr_last.
  - On grant, at the same edge:
    - latch owner, we, addr and wdata;
    - update rr_last to the owner;
    - load counter with LAT-1;
    - go to ACCESS.
- ACCESS:
  - mem_addr and mem_din driven from the latches.
  - Counter decrements each cycle.
  - Last cycle (counter==0):
    - mem_we = latched we (exactly one write pulse per write transaction);
    - for reads, mem_dout is captured into the owner's rdata register;
    - go to RESP.
  - mem_we is 0 in every other cycle.
- RESP:
  - Owner's done = 1 for exactly this cycle.
  - mem_we = 0; go to IDLE.
- Timing: req first seen in IDLE at cycle t → ACCESS cycles t+1..t+LAT → done in cycle t+LAT+1. Minimum spacing between grants is LAT+2 cycles.
- Outside ACCESS, mem_addr and mem_din are 0.
- Handshake:
  - req is a level; fields must stay stable from req assertion until done.
  - The requester drops req on the edge at which it samples done=1, otherwise a new transaction with the current fields is started.
  - A req arriving while busy waits; no request is lost or reordered.
- rdata holds its value until the next read completes for that port. Writes do not modify rdata.
- Only the owner's done asserts; the other port's done stays 0.
- Back-to-back with both ports requesting: grants alternate CPU, DMA, CPU, …
- A port dropping req while not granted is simply not served. Dropping req after grant has no effect: the transaction completes.
- Reset mid-ACCESS: transaction aborted, no mem_we pulse, no done, state IDLE.
- LAT=1: ACCESS lasts one cycle, and that cycle is also the write/capture cycle.

Decomposition:
- Shared package: state encoding localparams ARB_IDLE/ARB_ACCESS/ARB_RESP, and port IDs PORT_CPU=0, PORT_DMA=1.
- One natural sub-module, rr_arb2: combinational two-way round-robin pick from (req0, req1, last) → grant index and valid. rr_last itself is registered in dm_arbiter.

Test Plan:
- CPU read only, LAT=2, mem[5]=32'hDEADBEEF, cpu_req at t, cpu_addr=5, cpu_we=0 → mem_we never 1; cpu_done high only at t+3; cpu_rdata=32'hDEADBEEF from t+3; dma_done stays 0.
- DMA write, addr=10, wdata=32'h12345678, LAT=3 → mem_we high only at t+3 with mem_addr=10 and mem_din=32'h12345678; dma_done at t+4; a later read of addr 10 returns 32'h12345678.
- Both req held continuously from reset → grant order CPU, DMA, CPU, DMA; done pulses every LAT+2 cycles, alternating between ports.
- DMA req arrives mid CPU ACCESS → DMA granted in the IDLE cycle after CPU RESP; CPU transaction is unaffected.
- rst low during the write-pulse cycle of a write → mem_we 0, no done, busy 0; after rst release the memory word is unchanged.
- LAT=1, CPU read → done at t+2; rdata correct.
